// File: rtl/lcd_text_pkg.sv
// Shared constants, state encoding and addressing helper for the LCD text controller.
// The optional shadow-clear feature is enabled with macro LCD_TEXT_CLEAR_EN.
package lcd_text_pkg;

    localparam int LCD_ROWS = 4;
    localparam int LCD_COLS = 16;
    localparam logic [7:0] SPACE_CHAR = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROW12 = 3'd2,
        ST_ROW3  = 3'd3,
        ST_ROW4  = 3'd4
    } lcd_state_t;

    // Row-major byte index of a character cell.
    function automatic logic [5:0] cell_addr(input logic [1:0] row, input logic [3:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/lcd_text_buf.sv
// Shadow/live character buffers: writes go to the shadow, a swap copies all of it to live.
// With LCD_TEXT_CLEAR_EN defined, a clear pulse refills the shadow with spaces over 64 cycles.
module lcd_text_buf
    import lcd_text_pkg::*;
#(
    parameter int ROWS = LCD_ROWS,
    parameter int COLS = LCD_COLS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_accept,
    input  logic [1:0]        wr_row,
    input  logic [3:0]        wr_col,
    input  logic [7:0]        wr_char,
    input  logic              swap,
`ifdef LCD_TEXT_CLEAR_EN
    input  logic              clear,
    output logic              fill_busy,
`endif
    output logic [COLS*8-1:0] line0,
    output logic [COLS*8-1:0] line1,
    output logic [COLS*8-1:0] line2,
    output logic [COLS*8-1:0] line3
);

    localparam int DEPTH = ROWS * COLS;

    logic [7:0] shadow_r [DEPTH];
    logic [7:0] live_r   [DEPTH];
    logic [5:0] wr_addr_s;

    assign wr_addr_s = cell_addr(wr_row, wr_col);

`ifdef LCD_TEXT_CLEAR_EN
    logic       fill_busy_r;
    logic [5:0] fill_cnt_r;

    // Fill sequencer: one shadow byte per cycle, 64 cycles after a clear pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_busy_r <= 1'b0;
            fill_cnt_r  <= 6'd0;
        end else if (fill_busy_r) begin
            fill_cnt_r  <= fill_cnt_r + 6'd1;
            fill_busy_r <= (fill_cnt_r != 6'd63);
        end else if (clear) begin
            fill_busy_r <= 1'b1;
            fill_cnt_r  <= 6'd0;
        end
    end

    assign fill_busy = fill_busy_r;

    // Shadow buffer: fill has priority; the write port is held off by wr_ready meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) shadow_r[i] <= SPACE_CHAR;
        end else if (fill_busy_r) begin
            shadow_r[fill_cnt_r] <= SPACE_CHAR;
        end else if (wr_accept) begin
            shadow_r[wr_addr_s] <= wr_char;
        end
    end
`else
    // Shadow buffer write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) shadow_r[i] <= SPACE_CHAR;
        end else if (wr_accept) begin
            shadow_r[wr_addr_s] <= wr_char;
        end
    end
`endif

    // Live buffer: whole-image copy on swap only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) live_r[i] <= SPACE_CHAR;
        end else if (swap) begin
            for (int i = 0; i < DEPTH; i++) live_r[i] <= shadow_r[i];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign line0[(COLS-1-c)*8 +: 8] = live_r[c];
        assign line1[(COLS-1-c)*8 +: 8] = live_r[COLS+c];
        assign line2[(COLS-1-c)*8 +: 8] = live_r[2*COLS+c];
        assign line3[(COLS-1-c)*8 +: 8] = live_r[3*COLS+c];
    end

endmodule

// File: rtl/lcd_text_ctrlmod.sv
// LCD text controller top: frame sequencer driving the LCD write engine plus commit/swap control.
// Optional shadow-clear port and fill engine are enabled with macro LCD_TEXT_CLEAR_EN.
module lcd_text_ctrlmod
    import lcd_text_pkg::*;
#(
    parameter int ROWS = LCD_ROWS,
    parameter int COLS = LCD_COLS
) (
    input  logic              CLOCK,
    input  logic              RST_n,
    input  logic              run_en,
    input  logic              wr_en,
    output logic              wr_ready,
    input  logic [1:0]        wr_row,
    input  logic [3:0]        wr_col,
    input  logic [7:0]        wr_char,
    input  logic              commit,
    output logic              commit_pending,
`ifdef LCD_TEXT_CLEAR_EN
    input  logic              clear,
`endif
    output logic [COLS*8-1:0] line_rom1,
    output logic [COLS*8-1:0] line_rom2,
    output logic [COLS*8-1:0] line_rom3,
    output logic [COLS*8-1:0] line_rom4,
    output logic              iCall,
    input  logic              oDone,
    output logic              frame_done
);

    lcd_state_t state_r, state_s;
    logic init_done_r;
    logic call_r;
    logic frame_done_r;
    logic pending_r;
    logic ready_r;
    logic frame_end_s;
    logic swap_s;
    logic wr_accept_s;

    assign frame_end_s = (state_r == ST_ROW4) && oDone;

`ifdef LCD_TEXT_CLEAR_EN
    logic fill_busy_s;
    // A pending commit waits out the fill so the copied image is fully cleared.
    assign swap_s   = frame_end_s && pending_r && !fill_busy_s;
    assign wr_ready = ready_r && !swap_s && !fill_busy_s;
`else
    assign swap_s   = frame_end_s && pending_r;
    assign wr_ready = ready_r && !swap_s;
`endif

    assign wr_accept_s = wr_en && wr_ready;

    // Next-state logic of the frame sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run_en) state_s = init_done_r ? ST_ROW12 : ST_INIT;
                else        state_s = ST_IDLE;
            end
            ST_INIT: begin
                if (oDone) state_s = ST_ROW12;
                else       state_s = ST_INIT;
            end
            ST_ROW12: begin
                if (oDone) state_s = ST_ROW3;
                else       state_s = ST_ROW12;
            end
            ST_ROW3: begin
                if (oDone) state_s = ST_ROW4;
                else       state_s = ST_ROW3;
            end
            ST_ROW4: begin
                if (oDone) state_s = run_en ? ST_ROW12 : ST_IDLE;
                else       state_s = ST_ROW4;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Sequencer registers and registered outputs.
    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state_r      <= ST_IDLE;
            init_done_r  <= 1'b0;
            call_r       <= 1'b0;
            frame_done_r <= 1'b0;
            pending_r    <= 1'b0;
            ready_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            init_done_r  <= init_done_r || ((state_r == ST_INIT) && oDone);
            call_r       <= (state_s != ST_IDLE);
            frame_done_r <= frame_end_s;
            // A commit landing on the frame-end cycle survives into the next frame.
            pending_r    <= (pending_r && !swap_s) || commit;
            ready_r      <= 1'b1;
        end
    end

    assign iCall          = call_r;
    assign frame_done     = frame_done_r;
    assign commit_pending = pending_r;

    lcd_text_buf #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_buf (
        .clk       (CLOCK),
        .rst_n     (RST_n),
        .wr_accept (wr_accept_s),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_char   (wr_char),
        .swap      (swap_s),
`ifdef LCD_TEXT_CLEAR_EN
        .clear     (clear),
        .fill_busy (fill_busy_s),
`endif
        .line0     (line_rom1),
        .line1     (line_rom2),
        .line2     (line_rom3),
        .line3     (line_rom4)
    );

endmodule

// File: doc/lcd_text_ctrlmod.md
LCD_TEXT_CTRLMOD -- requirements
Module: lcd_text_ctrlmod

Interface
REQ-001 Parameter ROWS, default 4: number of display rows, fixed at 4.
REQ-002 Parameter COLS, default 16: characters per row, fixed at 16.
REQ-003 Port CLOCK, input, 1 bit: system clock, rising edge.
REQ-004 Port RST_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port run_en, input, 1 bit: 1 = keep the display refreshing; 0 = stop at the next frame end.
REQ-006 Port wr_en, input, 1 bit: character write request to the shadow buffer.
REQ-007 Port wr_ready, output, 1 bit: the write is accepted on a cycle where wr_en and wr_ready are both 1.
REQ-008 Port wr_row, input, 2 bits: target row, 0..3.
REQ-009 Port wr_col, input, 4 bits: target column, 0..15.
REQ-010 Port wr_char, input, 8 bits: character code.
REQ-011 Port commit, input, 1 bit: one-cycle pulse requesting a shadow-to-live copy.
REQ-012 Port commit_pending, output, 1 bit: a commit has been requested and not yet applied.
REQ-013 Ports line_rom1..line_rom4, output, 128 bits each: live rows 0..3; column 0 at [127:120], column 15 at [7:0].
REQ-014 Port iCall, output, 1 bit: enable to the LCD write engine.
REQ-015 Port oDone, input, 1 bit: one-cycle done pulse from the LCD write engine.
REQ-016 Port frame_done, output, 1 bit: one-cycle pulse at each frame end.

Function
REQ-017 Writes SHALL land only in the shadow buffer; the live buffer SHALL change only on a swap.
REQ-018 The state machine SHALL have states IDLE, INIT, ROW12, ROW3 and ROW4.
REQ-019 In IDLE, iCall SHALL be 0, and the block SHALL move to INIT when run_en is 1.
REQ-020 INIT SHALL move to ROW12 on the first oDone pulse, which marks init complete.
REQ-021 ROW12 SHALL move to ROW3 on an oDone pulse.
REQ-022 ROW3 SHALL move to ROW4 on an oDone pulse.
REQ-023 An oDone pulse in ROW4 is a frame end: it SHALL raise frame_done for 1 cycle, then go to ROW12 if run_en is 1, else to IDLE.
REQ-024 iCall SHALL be 1 in INIT, ROW12, ROW3 and ROW4, and registered.
REQ-025 On leaving ROW4 for IDLE, iCall SHALL fall the cycle after the oDone pulse.
REQ-026 run_en falling mid-frame SHALL NOT drop iCall before the frame end.
REQ-027 Leaving IDLE again SHALL return to ROW12, not INIT, because init is done once per reset.
REQ-028 commit SHALL set commit_pending; the pending flag SHALL clear in the frame-end cycle.
REQ-029 In the frame-end cycle with commit_pending set, all 64 live bytes SHALL update from the shadow buffer at once.
REQ-030 A commit arriving in the same cycle as a frame end SHALL be deferred to the next frame end.
REQ-031 wr_ready SHALL be 0 during the swap cycle.
REQ-032 A write and a swap in the same cycle SHALL NOT both occur: the write waits, and the copied image is the pre-write shadow.
REQ-033 Multiple commit pulses before a frame end SHALL collapse into one swap.
REQ-034 An oDone pulse in IDLE SHALL be ignored.

Reset
REQ-035 Asserting RST_n low SHALL force IDLE and clear iCall, frame_done and commit_pending.
REQ-036 Reset SHALL fill the shadow and live buffers with 8'h20 (space), so each line_rom reads all 8'h20.
REQ-037 wr_ready SHALL be 1 after reset (0 while RST_n is low).
REQ-038 Reset mid-frame SHALL restart from INIT, because the LCD engine is reset by the same RST_n.

Configuration
REQ-039 With macro LCD_TEXT_CLEAR_EN defined, input clear (1 bit pulse) SHALL fill the shadow buffer with 8'h20, one byte per cycle over 64 cycles.
REQ-040 While that fill runs, wr_ready SHALL be 0.
REQ-041 A commit during the fill SHALL stay pending and apply at the first frame end after the fill completes.
REQ-042 Without LCD_TEXT_CLEAR_EN, the clear port and fill counter SHALL be absent, and wr_ready SHALL depend only on the swap cycle.

Structure
REQ-043 Package lcd_text_pkg SHALL hold the ROWS/COLS constants, SPACE_CHAR = 8'h20, and the state encoding.
REQ-044 Sub-module lcd_text_buf SHALL hold the shadow and live arrays, the write port and the swap logic.
REQ-045 The sequencer SHALL live in the top module.

Verification
REQ-046 Reset, run_en=1, model the engine (init oDone, then 3 oDone per frame) -> iCall=1 one cycle after run_en, INIT->ROW12 on the first oDone, and frame_done after every 3rd oDone thereafter.
REQ-047 Write row 2 col 0 = 8'h41, then commit mid-frame -> line_rom3[127:120] stays 8'h20 until frame end, then reads 8'h41; commit_pending goes 1->0.
REQ-048 Commit in the same cycle as the frame-end oDone -> no swap this frame; swap at the next frame end.
REQ-049 run_en dropped in ROW12 -> iCall stays 1 through ROW3/ROW4, falls after the frame end; raise run_en again -> ROW12 with no INIT.
REQ-050 wr_en held high across the swap cycle -> wr_ready=0 that cycle, the write lands the next cycle, and the live buffer does not contain it.
REQ-051 LCD_TEXT_CLEAR_EN: write 16 x 8'h58 to row 0, clear, commit -> wr_ready low for 64 cycles, and line_rom1 = all 8'h20 after the next frame end.
